inst_rom_responder: RTL and testbench



---
 rtl/inst_rom_responder_pkg.sv | 16 +
 rtl/inst_fetch_buf.sv | 37 +++
 rtl/inst_rom_responder.sv | 181 ++++++++++++++++++
 tb/tb_inst_rom_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_rom_responder_pkg.sv
// Shared definitions for the IF-stage ROM responder: bus widths, FSM encoding, NOP.
package inst_rom_responder_pkg;

  localparam int BUS_ADDR_WIDTH = 32;
  localparam int BUS_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    SERVE    = 2'd0,
    FETCH    = 2'd1,
    ABORT    = 2'd2,
    PREFETCH = 2'd3
  } rom_state_e;

  localparam logic [BUS_DATA_WIDTH-1:0] NOP_INSTR = '0;

endpackage

// File: rtl/inst_fetch_buf.sv
// One fetch-buffer entry: tag/data/valid storage with a registered-input hit compare.
module inst_fetch_buf #(
  parameter int TAG_WIDTH  = 30,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [TAG_WIDTH-1:0]  wr_tag,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  inv,
  input  logic [TAG_WIDTH-1:0]  lookup_tag,
  output logic                  hit,
  output logic [TAG_WIDTH-1:0]  tag,
  output logic [DATA_WIDTH-1:0] data
);

  logic valid;

  // A write wins over an invalidate landing on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (wr_en) begin
      valid <= 1'b1;
      tag   <= wr_tag;
      data  <= wr_data;
    end else if (inv) begin
      valid <= 1'b0;
    end
  end

  assign hit = valid && (tag == lookup_tag);

endmodule

// File: rtl/inst_rom_responder.sv
// ROM fetch responder: serves IF fetches from a fetch buffer, refills from backing memory
// and stalls the pipeline on a miss. Define INST_ROM_PREFETCH_EN for a next-line prefetch entry.
module inst_rom_responder
  import inst_rom_responder_pkg::*;
#(
  parameter int ADDR_WIDTH     = BUS_ADDR_WIDTH,
  parameter int DATA_WIDTH     = BUS_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rom_en,
  input  logic [3:0]            rom_write_en,
  input  logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_write_data,
  output logic [DATA_WIDTH-1:0] rom_read_data,
  output logic                  stall_req,
  output logic                  bus_err,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int TAG_WIDTH = ADDR_WIDTH - 2;

  rom_state_e            state, state_nxt;
  logic [CNT_WIDTH-1:0]  cnt, cnt_nxt;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_valid;
  logic                  wr_err;
  logic [DATA_WIDTH-1:0] rd_hold;
  logic [TAG_WIDTH-1:0]  req_tag;
  logic                  sample, hit, abort_cycle, fill, timeout;
  logic                  main_hit, pf_hit;
  logic [TAG_WIDTH-1:0]  main_tag;
  logic [DATA_WIDTH-1:0] main_data, hit_data;
  logic                  main_wr;
  logic [TAG_WIDTH-1:0]  main_wr_tag;
  logic [DATA_WIDTH-1:0] main_wr_data;
  logic                  unused_bits;

  assign req_tag     = req_addr[ADDR_WIDTH-1:2];
  assign abort_cycle = (state == ABORT);
  assign fill        = (state == FETCH) && mem_ready;
  assign timeout     = (cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  // Hit is built from registered request state only, so stall_req never sees rom_addr.
  assign hit       = req_valid && (main_hit || pf_hit);
  assign stall_req = req_valid && !hit && !abort_cycle;
  assign sample    = !stall_req;
  assign bus_err   = abort_cycle || wr_err;

  inst_fetch_buf #(.TAG_WIDTH(TAG_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_main_buf (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (main_wr),
    .wr_tag     (main_wr_tag),
    .wr_data    (main_wr_data),
    .inv        (1'b0),
    .lookup_tag (req_tag),
    .hit        (main_hit),
    .tag        (main_tag),
    .data       (main_data)
  );

`ifdef INST_ROM_PREFETCH_EN
  logic                  pf_fill, promote;
  logic [TAG_WIDTH-1:0]  pf_tag, pf_req_tag;
  logic [DATA_WIDTH-1:0] pf_data;

  // A demand hit on the prefetched line moves it into the main entry.
  assign promote      = req_valid && pf_hit && !main_hit;
  assign pf_fill      = (state == PREFETCH) && mem_ready;
  assign main_wr      = fill || promote;
  assign main_wr_tag  = fill ? req_tag : pf_tag;
  assign main_wr_data = fill ? mem_rdata : pf_data;
  assign hit_data     = main_hit ? main_data : pf_data;

  inst_fetch_buf #(.TAG_WIDTH(TAG_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_pf_buf (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (pf_fill),
    .wr_tag     (pf_req_tag),
    .wr_data    (mem_rdata),
    .inv        (promote),
    .lookup_tag (req_tag),
    .hit        (pf_hit),
    .tag        (pf_tag),
    .data       (pf_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pf_req_tag <= '0;
    else if (fill) pf_req_tag <= req_tag + TAG_WIDTH'(1);
  end
`else
  assign pf_hit       = 1'b0;
  assign main_wr      = fill;
  assign main_wr_tag  = req_tag;
  assign main_wr_data = mem_rdata;
  assign hit_data     = main_data;
`endif

  assign unused_bits = ^{rom_write_data, req_addr[1:0], main_tag};

  always_comb begin
    rom_read_data = rd_hold;
    if (hit)              rom_read_data = hit_data;
    else if (abort_cycle) rom_read_data = DATA_WIDTH'(NOP_INSTR);
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mem_req   = 1'b0;
    mem_addr  = '0;
    case (state)
      SERVE: begin
        if (req_valid && !hit) begin
          state_nxt = FETCH;
          cnt_nxt   = '0;
        end
      end
      FETCH: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, 2'b00};
        if (mem_ready) begin
`ifdef INST_ROM_PREFETCH_EN
          state_nxt = PREFETCH;
`else
          state_nxt = SERVE;
`endif
          cnt_nxt   = '0;
        end else if (timeout) begin
          state_nxt = ABORT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      ABORT: state_nxt = SERVE;
`ifdef INST_ROM_PREFETCH_EN
      // Speculative transfer: a timeout here is dropped silently.
      PREFETCH: begin
        mem_req  = 1'b1;
        mem_addr = {pf_req_tag, 2'b00};
        if (mem_ready || timeout) begin
          state_nxt = SERVE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
`endif
      default: state_nxt = SERVE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SERVE;
      cnt       <= '0;
      req_addr  <= '0;
      req_valid <= 1'b0;
      wr_err    <= 1'b0;
      rd_hold   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rd_hold <= rom_read_data;
      wr_err  <= sample && rom_en && (rom_write_en != 4'b0000);
      if (sample) begin
        req_addr  <= rom_addr;
        req_valid <= rom_en;
      end
    end
  end

endmodule

// File: tb/tb_inst_rom_responder.sv
// Directed bench for inst_rom_responder: transaction-level buffer model plus per-cycle compare.
module tb_inst_rom_responder;

  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_en;
  logic [3:0]  rom_write_en;
  logic [31:0] rom_addr, rom_write_data, rom_read_data;
  logic        stall_req, bus_err, mem_req, mem_ready;
  logic [31:0] mem_addr, mem_rdata;

  int checks = 0;
  int errors = 0;

  // expected values the compare process uses
  logic [31:0] exp_rd    = '0;
  logic [31:0] exp_maddr = '0;
  bit          cmp_on    = 1'b0;
  int          mem_lat   = 0;

  // model: entry 0 = main buffer, entry 1 = prefetch entry
  bit          m_v [2];
  logic [29:0] m_t [2];
  logic [31:0] m_d [2];

  always #5 clk = ~clk;

  inst_rom_responder dut (
    .clk            (clk),
    .rst            (rst),
    .rom_en         (rom_en),
    .rom_write_en   (rom_write_en),
    .rom_addr       (rom_addr),
    .rom_write_data (rom_write_data),
    .rom_read_data  (rom_read_data),
    .stall_req      (stall_req),
    .bus_err        (bus_err),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ready      (mem_ready),
    .mem_rdata      (mem_rdata)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'hBFC00000) return 32'h3C08BFC0;
    return {a[15:0] ^ 16'hA5C3, a[31:16]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Backing memory: answers mem_lat cycles after a request starts; mem_lat=0 never answers.
  initial begin
    int wcnt;
    wcnt = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_ready) begin
        mem_ready = 1'b0;
        wcnt = 0;
      end
      if (mem_req) begin
        wcnt++;
        if (mem_lat != 0 && wcnt == mem_lat) begin
          mem_ready = 1'b1;
          mem_rdata = mem_word(mem_addr);
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (cmp_on) begin
        chk("cmp_rom_read_data", rom_read_data, exp_rd);
        if (mem_req) chk("cmp_mem_addr", mem_addr, exp_maddr);
`ifndef INST_ROM_PREFETCH_EN
        if (!stall_req) chk("cmp_no_spec_req", {31'd0, mem_req}, 32'd0);
`endif
      end
    end
  end

  // One fetch: sample at the next edge, wait for service, check against the model.
  task automatic fetch(input logic [31:0] a, input logic [3:0] we, input int lat,
                       input int lit_stall, input logic [31:0] lit_data);
    logic [29:0] t;
    bit          hm, hp, h, tmo;
    logic [31:0] ed;
    int          es, k, mc;
    t   = a[31:2];
    hm  = m_v[0] && (m_t[0] == t);
    hp  = 1'b0;
`ifdef INST_ROM_PREFETCH_EN
    hp  = m_v[1] && (m_t[1] == t);
`endif
    h   = hm || hp;
    tmo = !h && (lat == 0);
    ed  = hm ? m_d[0] : hp ? m_d[1] : tmo ? 32'h0 : mem_word({t, 2'b00});
    es  = h ? 0 : tmo ? TMO + 1 : lat + 1;
    exp_maddr      = {t, 2'b00};
    mem_lat        = lat;
    rom_en         = 1'b1;
    rom_addr       = a;
    rom_write_en   = we;
    rom_write_data = $urandom;
    @(negedge clk);
    rom_en       = 1'b0;
    rom_write_en = 4'h0;
    k  = 0;
    mc = 0;
    forever begin
      chk("bus_err", {31'd0, bus_err}, {31'd0, ((k == 0) && (we != 0)) || (tmo && k == es)});
      if (!stall_req || k > TMO + 20) break;
      if (mem_req) mc++;
      @(negedge clk);
      k++;
    end
    exp_rd = ed;
    chk("stall_cycles", k, es);
    chk("fetch_mem_cycles", mc, h ? 0 : tmo ? TMO : lat);
    chk("rom_read_data", rom_read_data, ed);
    if (lit_stall >= 0) begin
      chk("lit_stall", k, lit_stall);
      chk("lit_data", rom_read_data, lit_data);
    end
    if (hp && !hm) begin
      m_v[0] = 1'b1; m_t[0] = m_t[1]; m_d[0] = m_d[1]; m_v[1] = 1'b0;
    end else if (!h && !tmo) begin
      m_v[0] = 1'b1; m_t[0] = t; m_d[0] = ed;
`ifdef INST_ROM_PREFETCH_EN
      exp_maddr = {t + 30'd1, 2'b00};
      mc = 0;
      while (mem_req && mc < 300) begin
        @(negedge clk);
        mc++;
      end
      chk("prefetch_cycles", mc, lat);
      m_v[1] = 1'b1; m_t[1] = t + 30'd1; m_d[1] = mem_word({t + 30'd1, 2'b00});
`endif
    end
    if (tmo || h) chk("mem_req_idle", {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rom_en = 1'b0; rom_write_en = 4'h0; rom_addr = '0; rom_write_data = '0;
    m_v[0] = 1'b0; m_v[1] = 1'b0;
    @(negedge clk);
    chk("rst_rom_read_data", rom_read_data, 32'h0);
    chk("rst_stall_req", {31'd0, stall_req}, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    rst = 1'b0;
    cmp_on = 1'b1;
    @(negedge clk);
    chk("idle_stall_req", {31'd0, stall_req}, 32'd0);

    fetch(32'hBFC00000, 4'h0, 3, 4, 32'h3C08BFC0);   // cold miss, penalty latency+1
    fetch(32'hBFC00000, 4'h0, 3, 0, 32'h3C08BFC0);   // same word back-to-back: hit
    fetch(32'hBFC00002, 4'h0, 3, 0, 32'h3C08BFC0);   // low address bits ignored
    fetch(32'hBFC00000, 4'hF, 3, 0, 32'h3C08BFC0);   // write attempt on a hit
    fetch(32'hBFC00004, 4'h0, 1, -1, 32'h0);
    fetch(32'hBFC00000, 4'h0, 5, 6, 32'h3C08BFC0);
    fetch(32'h00001000, 4'h0, 0, 256, 32'h0);        // timeout -> abort NOP
    fetch(32'hBFC00000, 4'h0, 3, 0, 32'h3C08BFC0);   // buffer survived the abort
    fetch(32'h00002000, 4'h1, 2, 3, 32'h85C30000);   // write attempt on a miss
    fetch(32'hFFFFFFFC, 4'h0, 2, 3, 32'h5A3FFFFF);   // top of address space
    fetch(32'hFFFFFFFF, 4'h0, 2, 0, 32'h5A3FFFFF);

    // reset in the middle of a FETCH
    exp_maddr = 32'h00003000;
    mem_lat = 0;
    rom_en = 1'b1; rom_addr = 32'h00003000; rom_write_en = 4'h0;
    @(negedge clk);
    rom_en = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_fetch_mem_req", {31'd0, mem_req}, 32'd1);
    chk("mid_fetch_stall", {31'd0, stall_req}, 32'd1);
    rst = 1'b1;
    exp_rd = 32'h0;
    #2;
    chk("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("async_rst_stall", {31'd0, stall_req}, 32'd0);
    chk("async_rst_mem_addr", mem_addr, 32'h0);
    chk("async_rst_rom_read_data", rom_read_data, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_v[0] = 1'b0; m_v[1] = 1'b0;
    fetch(32'hFFFFFFFC, 4'h0, 2, 3, 32'h5A3FFFFF);   // buffer was invalidated

    fetch(32'h00000100, 4'h0, 2, 3, 32'hA4C30000);
`ifdef INST_ROM_PREFETCH_EN
    fetch(32'h00000104, 4'h0, 2, 0, 32'hA4C70000);   // served from the prefetch entry
`else
    fetch(32'h00000104, 4'h0, 2, 3, 32'hA4C70000);
`endif
    repeat (2) @(negedge clk);
    chk("final_stall_req", {31'd0, stall_req}, 32'd0);
    chk("final_bus_err", {31'd0, bus_err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
